tt_scan: RTL and testbench

TT_SCAN -- requirements
Module: tt_scan

---
 rtl/tt_scan.sv | 103 ++++++++++
 tb/tb_tt_scan.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tt_scan.sv
// Truth-table scanner: steps {a,b,c,d} through 0..15, holding each vector DWELL cycles, and captures f per vector.
// Latency: done pulses 16*DWELL edges after the start edge; no input backpressure (start ignored while busy).
module tt_scan #(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    input  logic        f,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  err_count,
    output logic        pass
);

    typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [7:0]  dwell_cnt;
    logic        sample_edge;
    logic [4:0]  err_nxt;

    assign sample_edge = (state == DRIVE) && (dwell_cnt == DWELL_LAST);

    // Saturating at 16 keeps the count meaningful even if the width ever grows.
    always_comb begin
        err_nxt = err_count;
        if ((f != expected[idx]) && (err_count != 5'd16))
            err_nxt = err_count + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE: begin
                if (abort)
                    state_nxt = IDLE;
                else if (sample_edge && (idx == 4'd15))
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 4'd0;
            dwell_cnt <= 8'd0;
            tt        <= 16'h0000;
            err_count <= 5'd0;
            pass      <= 1'b0;
        end else if ((state == IDLE) && start) begin
            idx       <= 4'd0;
            dwell_cnt <= 8'd0;
            tt        <= 16'h0000;
            err_count <= 5'd0;
            pass      <= 1'b0;
        end else if (state == DRIVE) begin
            if (abort) begin
                // Abort wins over a coincident sample: the pending bit is dropped.
                idx       <= 4'd0;
                dwell_cnt <= 8'd0;
                pass      <= 1'b0;
            end else if (sample_edge) begin
                tt[idx]   <= f;
                err_count <= err_nxt;
                dwell_cnt <= 8'd0;
                idx       <= idx + 4'd1;
                if (idx == 4'd15)
                    pass <= (err_nxt == 5'd0);
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        busy         = (state == DRIVE);
        done         = (state == FIN);
        {a, b, c, d} = (state == DRIVE) ? idx : 4'd0;
    end

endmodule

// File: tb/tb_tt_scan.sv
// Bench for tt_scan: two instances (DWELL=4 and DWELL=1) checked cycle by cycle against a timing/arithmetic model.
module tb_tt_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start, abort, f;
    logic [1:0]  a, b, c, d, busy, done, pass;
    logic [15:0] expected [2];
    logic [15:0] tt [2];
    logic [4:0]  err_count [2];
    logic [15:0] fn [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign f[0] = fn[0][{a[0], b[0], c[0], d[0]}];
    assign f[1] = fn[1][{a[1], b[1], c[1], d[1]}];

    tt_scan #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .expected(expected[0]), .f(f[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
        .busy(busy[0]), .done(done[0]), .tt(tt[0]),
        .err_count(err_count[0]), .pass(pass[0])
    );

    tt_scan #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .expected(expected[1]), .f(f[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]),
        .busy(busy[1]), .done(done[1]), .tt(tt[1]),
        .err_count(err_count[1]), .pass(pass[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int dw(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    task automatic chk_idle_outputs(input int u, input string tag);
        chk({tag, "_busy"}, busy[u], 0);
        chk({tag, "_done"}, done[u], 0);
        chk({tag, "_vec"}, {a[u], b[u], c[u], d[u]}, 0);
    endtask

    // One scan from the start edge (k) to one cycle past the done edge. Each vector's
    // expected bit is read at its own sample edge; abort/restart are given as edge offsets from k.
    task automatic run_scan(input int u, input logic [15:0] func, input bit rand_exp,
                            input logic [15:0] exp_fixed, input int abort_edge,
                            input int restart_edge);
        int          dwell;
        int          total;
        int          vi;
        int          m_err;
        logic [15:0] m_tt;
        bit          aborted;
        dwell   = dw(u);
        total   = 16 * dwell;
        m_tt    = 16'h0000;
        m_err   = 0;
        aborted = 0;
        fn[u]   = func;
        @(negedge clk);
        expected[u] = rand_exp ? 16'($urandom) : exp_fixed;
        start[u]    = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= total + 1; m++) begin
            @(negedge clk);
            start[u] = 1'b0;
            abort[u] = 1'b0;
            if (aborted || m > total) begin
                chk_idle_outputs(u, "after");
            end else if (m == total) begin
                chk("fin_busy", busy[u], 0);
                chk("fin_done", done[u], 1);
                chk("fin_vec", {a[u], b[u], c[u], d[u]}, 0);
                chk("fin_pass", pass[u], (m_err == 0));
            end else begin
                chk("run_busy", busy[u], 1);
                chk("run_done", done[u], 0);
                chk("run_vec", {a[u], b[u], c[u], d[u]}, m / dwell);
            end
            if (!aborted && m + 1 <= total) begin
                if (rand_exp) expected[u] = 16'($urandom);
                if (m + 1 == abort_edge) begin
                    abort[u] = 1'b1;
                    aborted  = 1;
                end else if ((m + 1) % dwell == 0) begin
                    vi = (m + 1) / dwell - 1;
                    m_tt[vi] = func[vi];
                    if (func[vi] != expected[u][vi] && m_err < 16) m_err++;
                end
            end
            if (m + 1 == restart_edge) start[u] = 1'b1;
        end
        chk("end_tt", tt[u], m_tt);
        chk("end_err", err_count[u], m_err);
        chk("end_pass", pass[u], (!aborted && m_err == 0));
    endtask

    initial begin
        logic [15:0] keep_tt;
        logic [4:0]  keep_err;
        rst_n = 1'b0;
        start = 2'b00;
        abort = 2'b00;
        expected[0] = 16'h0; expected[1] = 16'h0;
        fn[0] = 16'h0; fn[1] = 16'h0;
        #12;
        for (int u = 0; u < 2; u++) begin
            chk_idle_outputs(u, "reset");
            chk("reset_tt", tt[u], 0);
            chk("reset_err", err_count[u], 0);
            chk("reset_pass", pass[u], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // f = a&b against F000: clean pass
        run_scan(0, 16'hF000, 0, 16'hF000, -1, -1);
        chk("ab_tt", tt[0], 16'hF000);
        chk("ab_pass", pass[0], 1);
        // f = d against F000: eight mismatches
        run_scan(0, 16'hAAAA, 0, 16'hF000, -1, -1);
        chk("d_tt", tt[0], 16'hAAAA);
        chk("d_err", err_count[0], 8);
        // DWELL=1, f = ~a
        run_scan(1, 16'h00FF, 0, 16'h00FF, -1, -1);
        chk("na_tt", tt[1], 16'h00FF);
        chk("na_pass", pass[1], 1);
        // start mid-scan and during FIN must be ignored
        run_scan(0, 16'hF000, 0, 16'hF000, -1, 10);
        run_scan(1, 16'h1234, 0, 16'h1234, -1, 17);
        // abort seen just after the vector-4 sample, then abort coinciding with the vector-5 sample
        run_scan(0, 16'hFFFF, 0, 16'hFFFF, 21, -1);
        chk("abort_tt", tt[0], 16'h001F);
        run_scan(0, 16'hFFFF, 0, 16'hFFFF, 24, -1);
        chk("abort_coinc_tt", tt[0], 16'h001F);
        // every vector wrong: count reaches 16
        run_scan(1, 16'hFFFF, 0, 16'h0000, -1, -1);
        chk("all_wrong_err", err_count[1], 16);

        // abort in IDLE leaves results untouched
        keep_tt  = tt[1];
        keep_err = err_count[1];
        @(negedge clk);
        abort[1] = 1'b1;
        repeat (3) @(negedge clk);
        abort[1] = 1'b0;
        chk("idle_abort_tt", tt[1], keep_tt);
        chk("idle_abort_err", err_count[1], keep_err);
        chk_idle_outputs(1, "idle_abort");

        for (int r = 0; r < 8; r++)
            run_scan(r % 2, 16'($urandom), 1, 16'h0, -1, -1);

        // asynchronous reset mid-scan
        fn[0] = 16'hFFFF;
        @(negedge clk);
        expected[0] = 16'h0000;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_idle_outputs(0, "arst");
        chk("arst_tt", tt[0], 0);
        chk("arst_err", err_count[0], 0);
        chk("arst_pass", pass[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(0, 16'h6996, 0, 16'h6996, -1, -1);
        chk("post_arst_tt", tt[0], 16'h6996);
        chk("post_arst_pass", pass[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
